// File: rtl/ise_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ise_seq_ctrl
//
// Sequencer for the image-sort engine. It streams PIX_PER_IMG pixels per
// image into an external accumulator, asks the datapath to classify every
// accumulated image, records {color, tag} for each of IMG_NUM images, and
// then replays the records grouped by color (0,1,2,3). Within a color group
// the arrival order is kept.
//
// Ports
//   clk             : single clock, rising edge
//   reset           : asynchronous, active-low reset
//   image_in_index  : tag of the image currently being streamed
//   busy            : pixel presented this cycle is not accepted
//   acc_en          : datapath accumulates pixel_in this cycle
//   acc_clr         : datapath loads instead of adds (first pixel)
//   pix_last        : last pixel of the image
//   cls_req         : classification request (registered)
//   cls_ack         : classification result valid
//   cls_color       : classification result (0 red,1 green,2 blue,3 undet.)
//   out_valid       : one sorted result is presented
//   color_index     : color of the presented result
//   image_out_index : tag of the presented result
// ---------------------------------------------------------------------------
module ise_seq_ctrl #(
    parameter int IMG_NUM     = 32,
    parameter int PIX_PER_IMG = 16384
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] image_in_index,
    output logic       busy,
    output logic       acc_en,
    output logic       acc_clr,
    output logic       pix_last,
    output logic       cls_req,
    input  logic       cls_ack,
    input  logic [1:0] cls_color,
    output logic       out_valid,
    output logic [1:0] color_index,
    output logic [4:0] image_out_index
);

    localparam int PIX_W  = $clog2(PIX_PER_IMG);
    localparam int IMG_W  = (IMG_NUM > 1) ? $clog2(IMG_NUM) : 1;
    localparam int EMIT_W = $clog2(IMG_NUM + 1);

    typedef enum logic [1:0] {
        INGEST   = 2'd0,
        CLASSIFY = 2'd1,
        OUTPUT   = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [PIX_W-1:0]  pix_cnt;
    logic [IMG_W-1:0]  img_cnt;
    logic [IMG_W-1:0]  scan_slot;
    logic [1:0]        scan_pass;
    logic [EMIT_W-1:0] emit_cnt;
    logic [4:0]        cur_tag;

    // One record per image: {color[1:0], tag[4:0]}
    logic [6:0]        slot_tbl [IMG_NUM];

    logic              ack_take;
    logic              img_end;
    logic              scan_end;
    logic [6:0]        scan_entry;
    logic              scan_hit;

    assign img_end    = (img_cnt == IMG_W'(IMG_NUM - 1));
    assign scan_entry = slot_tbl[scan_slot];
    // The emit bound is a guard only: a well-formed table yields exactly
    // IMG_NUM hits over the four passes.
    assign scan_hit   = (scan_entry[6:5] == scan_pass) &&
                        (emit_cnt != EMIT_W'(IMG_NUM));

    // -----------------------------------------------------------------------
    // Next-state and decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        pix_last  = 1'b0;
        ack_take  = 1'b0;
        scan_end  = 1'b0;
        case (state)
            INGEST: begin
                busy     = 1'b0;
                acc_en   = 1'b1;
                acc_clr  = (pix_cnt == '0);
                pix_last = (pix_cnt == PIX_W'(PIX_PER_IMG - 1));
                if (pix_last) begin
                    state_nxt = CLASSIFY;
                end
            end
            CLASSIFY: begin
                // An ack seen before the request is raised is not a reply.
                ack_take = cls_req && cls_ack;
                if (ack_take) begin
                    state_nxt = img_end ? OUTPUT : INGEST;
                end
            end
            OUTPUT: begin
                scan_end = (scan_pass == 2'd3) &&
                           (scan_slot == IMG_W'(IMG_NUM - 1));
                if (scan_end) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = INGEST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INGEST;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Counters, request and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt         <= '0;
            img_cnt         <= '0;
            scan_slot       <= '0;
            scan_pass       <= '0;
            emit_cnt        <= '0;
            cur_tag         <= '0;
            cls_req         <= 1'b0;
            out_valid       <= 1'b0;
            color_index     <= '0;
            image_out_index <= '0;
        end else begin
            if (state == INGEST) begin
                // Power-of-two size: wraps to 0 on the last pixel.
                pix_cnt <= pix_cnt + 1'b1;
                if (acc_clr) begin
                    cur_tag <= image_in_index;
                end
            end

            // Raised the cycle after CLASSIFY entry, dropped by the ack edge.
            cls_req <= (state == CLASSIFY) && !ack_take;

            if (ack_take) begin
                img_cnt <= img_cnt + 1'b1;
            end

            if (state == OUTPUT) begin
                out_valid <= scan_hit;
                if (scan_hit) begin
                    color_index     <= scan_entry[6:5];
                    image_out_index <= scan_entry[4:0];
                    emit_cnt        <= emit_cnt + 1'b1;
                end
                if (scan_slot == IMG_W'(IMG_NUM - 1)) begin
                    scan_slot <= '0;
                    scan_pass <= scan_pass + 1'b1;
                end else begin
                    scan_slot <= scan_slot + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Result table carries no reset; every slot is written before the scan.
    always_ff @(posedge clk) begin
        if (ack_take) begin
            slot_tbl[img_cnt] <= {cls_color, cur_tag};
        end
    end

endmodule
